// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480@60 timing constants, counter width and axis phase type.
package vga_timing_pkg;

   localparam int CNT_W = 10;
   localparam int RGB_W = 12;

   localparam int H_SYNC_D   = 96;
   localparam int H_BP_D     = 48;
   localparam int H_ACTIVE_D = 640;
   localparam int H_FP_D     = 16;
   localparam int H_TOTAL    = H_SYNC_D + H_BP_D + H_ACTIVE_D + H_FP_D;

   localparam int V_SYNC_D   = 2;
   localparam int V_BP_D     = 33;
   localparam int V_ACTIVE_D = 480;
   localparam int V_FP_D     = 10;
   localparam int V_TOTAL    = V_SYNC_D + V_BP_D + V_ACTIVE_D + V_FP_D;

   localparam int H_ACT_START = H_SYNC_D + H_BP_D;
   localparam int H_ACT_END   = H_ACT_START + H_ACTIVE_D - 1;
   localparam int V_ACT_START = V_SYNC_D + V_BP_D;
   localparam int V_ACT_END   = V_ACT_START + V_ACTIVE_D - 1;

   typedef enum logic [1:0] {
      PH_SYNC,
      PH_BP,
      PH_ACTIVE,
      PH_FP
   } axis_phase_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: position counter with SYNC/BP/ACTIVE/FP phase decoded from the count.
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int SYNC   = H_SYNC_D,
   parameter int BP     = H_BP_D,
   parameter int ACTIVE = H_ACTIVE_D,
   parameter int FP     = H_FP_D
) (
   input  logic             vga_CLK,
   input  logic             rst_n,
   input  logic             advance,
   output logic [CNT_W-1:0] count,
   output axis_phase_e      phase,
   output logic             sync_n,
   output logic             active,
   output logic             wrap
);

   localparam logic [CNT_W-1:0] BP_START  = CNT_W'(SYNC);
   localparam logic [CNT_W-1:0] ACT_START = CNT_W'(SYNC + BP);
   localparam logic [CNT_W-1:0] FP_START  = CNT_W'(SYNC + BP + ACTIVE);
   localparam logic [CNT_W-1:0] LAST      = CNT_W'(SYNC + BP + ACTIVE + FP - 1);

   logic [CNT_W-1:0] count_nxt;

   // Phase follows directly from the position; next position steps only on advance.
   always_comb begin
      phase     = PH_FP;
      count_nxt = count;
      if (count < BP_START) begin
         phase = PH_SYNC;
      end else if (count < ACT_START) begin
         phase = PH_BP;
      end else if (count < FP_START) begin
         phase = PH_ACTIVE;
      end
      if (advance) begin
         count_nxt = (count == LAST) ? '0 : count + CNT_W'(1);
      end
   end

   assign sync_n = (phase != PH_SYNC);
   assign active = (phase == PH_ACTIVE);
   assign wrap   = advance && (count == LAST);

   // Position register; reset parks the axis at the start of the sync phase.
   always_ff @(posedge vga_CLK or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA timing generator and output stage: pixel position for the renderer, frame
// pulse/counter, and sync/RGB outputs aligned to the renderer's pixel latency.
// Optional macro VGA_SYNC_GEN_BLANK_EN adds VGA_BLANK_N / VGA_SYNC_N for the ADV7123.
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_SYNC   = H_SYNC_D,
   parameter int H_BP     = H_BP_D,
   parameter int H_ACTIVE = H_ACTIVE_D,
   parameter int H_FP     = H_FP_D,
   parameter int V_SYNC   = V_SYNC_D,
   parameter int V_BP     = V_BP_D,
   parameter int V_ACTIVE = V_ACTIVE_D,
   parameter int V_FP     = V_FP_D,
   parameter int PIPE_DLY = 1
) (
   input  logic             vga_CLK,
   input  logic             rst_n,
   output logic [CNT_W-1:0] pos_H,
   output logic [CNT_W-1:0] pos_V,
   output logic             ready,
   output logic             frame_start,
   output logic [7:0]       frame_cnt,
   input  logic [RGB_W-1:0] rgb_in,
   output logic             VGA_HS,
   output logic             VGA_VS,
`ifdef VGA_SYNC_GEN_BLANK_EN
   output logic             VGA_BLANK_N,
   output logic             VGA_SYNC_N,
`endif
   output logic [RGB_W-1:0] VGA_RGB
);

   if ((H_SYNC + H_BP + H_ACTIVE + H_FP > 1023) ||
       (V_SYNC + V_BP + V_ACTIVE + V_FP > 1023)) begin : g_bad_total
      $error("vga_sync_gen: timing totals exceed the 10-bit counter range");
   end
   if ((PIPE_DLY < 1) || (PIPE_DLY > 4)) begin : g_bad_dly
      $error("vga_sync_gen: PIPE_DLY must be within 1..4");
   end

   axis_phase_e h_phase;
   axis_phase_e v_phase;
   logic        h_sync_n;
   logic        v_sync_n;
   logic        h_active;
   logic        v_active;
   logic        h_wrap;
   logic        v_wrap;

   vga_axis_counter #(
      .SYNC   (H_SYNC),
      .BP     (H_BP),
      .ACTIVE (H_ACTIVE),
      .FP     (H_FP)
   ) u_h_axis (
      .vga_CLK (vga_CLK),
      .rst_n   (rst_n),
      .advance (1'b1),
      .count   (pos_H),
      .phase   (h_phase),
      .sync_n  (h_sync_n),
      .active  (h_active),
      .wrap    (h_wrap)
   );

   vga_axis_counter #(
      .SYNC   (V_SYNC),
      .BP     (V_BP),
      .ACTIVE (V_ACTIVE),
      .FP     (V_FP)
   ) u_v_axis (
      .vga_CLK (vga_CLK),
      .rst_n   (rst_n),
      .advance (h_wrap),
      .count   (pos_V),
      .phase   (v_phase),
      .sync_n  (v_sync_n),
      .active  (v_active),
      .wrap    (v_wrap)
   );

   // Phase enums and the frame wrap are informational here; the flags carry the same facts.
   logic unused_sink;
   assign unused_sink = ^{h_phase, v_phase, v_wrap};

   assign ready = h_active && v_active;

   // Gated by rst_n so the (0,0) pulse stays quiet while the block is held in reset.
   assign frame_start = rst_n && (pos_H == '0) && (pos_V == '0);

   // Frame counter bumps on the edge that closes the frame_start cycle.
   always_ff @(posedge vga_CLK or negedge rst_n) begin
      if (!rst_n) begin
         frame_cnt <= '0;
      end else if (frame_start) begin
         frame_cnt <= frame_cnt + 8'd1;
      end
   end

   // vld_p tracks ready through the renderer latency; hs_p/vs_p add one more stage
   // so sync lines up with the registered RGB output.
   logic [PIPE_DLY-1:0] vld_p;
   logic [PIPE_DLY:0]   hs_p;
   logic [PIPE_DLY:0]   vs_p;
   logic                act_d;

   assign act_d  = vld_p[PIPE_DLY-1];
   assign VGA_HS = hs_p[PIPE_DLY];
   assign VGA_VS = vs_p[PIPE_DLY];

   // Delay lines shift toward the MSB; reset loads the inactive levels.
   always_ff @(posedge vga_CLK or negedge rst_n) begin
      if (!rst_n) begin
         vld_p <= '0;
         hs_p  <= '1;
         vs_p  <= '1;
      end else begin
         vld_p <= PIPE_DLY'({vld_p, ready});
         hs_p  <= (PIPE_DLY + 1)'({hs_p, h_sync_n});
         vs_p  <= (PIPE_DLY + 1)'({vs_p, v_sync_n});
      end
   end

   // Output register: pass the renderer pixel only inside the delayed active window.
   always_ff @(posedge vga_CLK or negedge rst_n) begin
      if (!rst_n) begin
         VGA_RGB <= '0;
      end else begin
         VGA_RGB <= act_d ? rgb_in : '0;
      end
   end

`ifdef VGA_SYNC_GEN_BLANK_EN
   assign VGA_SYNC_N = 1'b0;

   // DAC blank strobe registered alongside VGA_RGB.
   always_ff @(posedge vga_CLK or negedge rst_n) begin
      if (!rst_n) begin
         VGA_BLANK_N <= 1'b0;
      end else begin
         VGA_BLANK_N <= act_d;
      end
   end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench for vga_sync_gen. The vertical axis is shortened to 12 lines
// (sync 2, bp 3, active 5, fp 2) so a whole frame is 9600 cycles; horizontal
// timing is the standard 800-clock line.
module tb_vga_sync_gen;

   localparam int HT    = 800;
   localparam int VT    = 12;
   localparam int FRAME = HT * VT;

   logic        vga_CLK = 1'b0;
   logic        rst_n;
   logic [9:0]  pos_H;
   logic [9:0]  pos_V;
   logic        ready;
   logic        frame_start;
   logic [7:0]  frame_cnt;
   logic [11:0] rgb_in;
   logic        VGA_HS;
   logic        VGA_VS;
   logic [11:0] VGA_RGB;
`ifdef VGA_SYNC_GEN_BLANK_EN
   logic        VGA_BLANK_N;
   logic        VGA_SYNC_N;
`endif

   int errors = 0;
   int checks = 0;

   always #5 vga_CLK = ~vga_CLK;

   vga_sync_gen #(
      .V_SYNC   (2),
      .V_BP     (3),
      .V_ACTIVE (5),
      .V_FP     (2),
      .PIPE_DLY (1)
   ) dut (
      .vga_CLK     (vga_CLK),
      .rst_n       (rst_n),
      .pos_H       (pos_H),
      .pos_V       (pos_V),
      .ready       (ready),
      .frame_start (frame_start),
      .frame_cnt   (frame_cnt),
      .rgb_in      (rgb_in),
      .VGA_HS      (VGA_HS),
      .VGA_VS      (VGA_VS),
`ifdef VGA_SYNC_GEN_BLANK_EN
      .VGA_BLANK_N (VGA_BLANK_N),
      .VGA_SYNC_N  (VGA_SYNC_N),
`endif
      .VGA_RGB     (VGA_RGB)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge vga_CLK);
      @(negedge vga_CLK);
   endtask

   // Active window of the shortened frame, from the cycle index since (0,0).
   function automatic bit in_act(input int c);
      int h;
      int v;
      h = c % HT;
      v = (c / HT) % VT;
      return (h >= 144) && (h <= 783) && (v >= 5) && (v <= 9);
   endfunction

   int          pos_bad, rdy_bad, fs_bad, rgb_bad, hs_bad, vs_bad, blank_bad, sync_bad;
   int          rdy_cnt, first_rdy, wraps, last_wrap, wrap_bad;
   int          hs_low, vs_low, rgb_cnt, first_rgb, run, max_run, n;
   logic [11:0] exp_rgb;
   bit          exp_hs, exp_vs;

   initial begin
      rst_n  = 1'b0;
      rgb_in = 12'hABC;
      pos_bad = 0; rdy_bad = 0; fs_bad = 0; rgb_bad = 0; hs_bad = 0; vs_bad = 0;
      blank_bad = 0; sync_bad = 0; rdy_cnt = 0; first_rdy = -1; wraps = 0;
      last_wrap = -1; wrap_bad = 0; hs_low = 0; vs_low = 0; rgb_cnt = 0;
      first_rgb = -1; run = 0; max_run = 0;

      repeat (3) step();
      chk("rst_pos_H", pos_H, 0);
      chk("rst_pos_V", pos_V, 0);
      chk("rst_ready", ready, 0);
      chk("rst_frame_start", frame_start, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      chk("rst_hs", VGA_HS, 1);
      chk("rst_vs", VGA_VS, 1);
      chk("rst_rgb", VGA_RGB, 0);

      rst_n = 1'b1;
      #1;
      chk("rel_frame_start", frame_start, 1);

      for (int c = 0; c < FRAME; c++) begin
         if (c > 0) step();
         if (pos_H !== 10'(c % HT) || pos_V !== 10'((c / HT) % VT)) pos_bad++;
         if (ready !== in_act(c)) rdy_bad++;
         if (frame_start !== (c == 0)) fs_bad++;
         if (ready === 1'b1) begin
            rdy_cnt++;
            if (first_rdy < 0) first_rdy = c;
         end
         if (pos_H === 10'd0) begin
            if (last_wrap >= 0 && (c - last_wrap) != HT) wrap_bad++;
            last_wrap = c;
            wraps++;
         end
         exp_rgb = (c >= 2 && in_act(c - 2)) ? 12'hABC : 12'h000;
         exp_hs  = (c < 2) ? 1'b1 : (((c - 2) % HT) >= 96);
         exp_vs  = (c < 2) ? 1'b1 : ((((c - 2) / HT) % VT) >= 2);
         if (VGA_RGB !== exp_rgb) rgb_bad++;
         if (VGA_HS !== exp_hs) hs_bad++;
         if (VGA_VS !== exp_vs) vs_bad++;
         if (VGA_HS === 1'b0) hs_low++;
         if (VGA_VS === 1'b0) vs_low++;
         if (VGA_RGB === 12'hABC) begin
            rgb_cnt++;
            run++;
            if (run > max_run) max_run = run;
            if (first_rgb < 0) first_rgb = c;
         end else begin
            run = 0;
         end
`ifdef VGA_SYNC_GEN_BLANK_EN
         if (VGA_BLANK_N !== (exp_rgb != 12'h000)) blank_bad++;
         if (VGA_SYNC_N !== 1'b0) sync_bad++;
`endif
         if (c <= 2) chk("hs_release_align", VGA_HS, (c < 2) ? 1 : 0);
         if (c == 1) chk("frame_cnt_after_first", frame_cnt, 1);
      end

      chk("pos_sequence_bad", pos_bad, 0);
      chk("ready_window_bad", rdy_bad, 0);
      chk("frame_start_bad", fs_bad, 0);
      chk("ready_cycles", rdy_cnt, 3200);
      chk("first_ready_cycle", first_rdy, 5 * HT + 144);
      chk("line_wraps", wraps, VT);
      chk("line_len_bad", wrap_bad, 0);
      chk("rgb_bad", rgb_bad, 0);
      chk("hs_bad", hs_bad, 0);
      chk("vs_bad", vs_bad, 0);
      chk("hs_low_cycles", hs_low, 96 * VT);
      chk("vs_low_cycles", vs_low, 1600);
      chk("rgb_cycles", rgb_cnt, 3200);
      chk("rgb_max_run", max_run, 640);
      chk("first_rgb_cycle", first_rgb, 5 * HT + 144 + 2);
`ifdef VGA_SYNC_GEN_BLANK_EN
      chk("blank_n_bad", blank_bad, 0);
      chk("sync_n_bad", sync_bad, 0);
`endif

      step();
      chk("frame2_start", frame_start, 1);
      chk("frame2_pos_H", pos_H, 0);
      chk("frame2_pos_V", pos_V, 0);
      chk("frame2_cnt_before", frame_cnt, 1);
      step();
      chk("frame2_cnt_after", frame_cnt, 2);
      chk("frame2_pulse_ends", frame_start, 0);

      repeat ((FRAME + 7 * HT + 400) - (FRAME + 1)) step();
      chk("mid_pos_H", pos_H, 400);
      chk("mid_pos_V", pos_V, 7);
      chk("mid_rgb", VGA_RGB, 12'hABC);
      chk("mid_ready", ready, 1);

      rst_n = 1'b0;
      #1;
      chk("arst_pos_H", pos_H, 0);
      chk("arst_pos_V", pos_V, 0);
      chk("arst_ready", ready, 0);
      chk("arst_frame_start", frame_start, 0);
      chk("arst_frame_cnt", frame_cnt, 0);
      chk("arst_rgb", VGA_RGB, 0);
      chk("arst_hs", VGA_HS, 1);
      chk("arst_vs", VGA_VS, 1);

      @(negedge vga_CLK);
      repeat (2) step();
      rst_n = 1'b1;
      #1;
      chk("rerel_frame_start", frame_start, 1);
      n = 0;
      do begin
         step();
         n++;
      end while (pos_H !== 10'd0 && n < 2000);
      chk("rerel_line_len", n, 800);
      chk("rerel_pos_V", pos_V, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
